// File: rtl/mult_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multi-cycle MULT/DIV responder: default operand
// width and iteration count, FSM state encodings and operation encodings.
// No ports (package).
// ----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned STEPS_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle signed multiply / divide responder for the control unit.
// Radix-2 shift-add multiply or restoring divide on operand magnitudes, one
// iteration per clock, with sign fix-up applied when the result is registered.
//
// Ports
//   clock       in   1      single clock, all state on posedge
//   reset       in   1      asynchronous, active-low
//   start_mult  in   1      request signed a*b (wins if both starts are high)
//   start_div   in   1      request signed a/b
//   a           in   WIDTH  multiplicand / dividend, sampled at acceptance
//   b           in   WIDTH  multiplier / divisor, sampled at acceptance
//   busy        out  1      high in RUN and DONE; starts ignored while high
//   done        out  1      one-cycle pulse, hi/lo/div_zero valid
//   div_zero    out  1      divisor was zero; held until next accepted start
//   hi          out  WIDTH  product upper half / remainder (sign of dividend)
//   lo          out  WIDTH  product lower half / quotient (toward zero)
// ----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned STEPS = STEPS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(STEPS) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    // Two's-complement negation at operand width.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // Magnitude of a signed operand; -2^(WIDTH-1) maps to its unsigned value.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? f_neg(v) : v;
    endfunction

    state_e             r_state;
    state_e             w_next_state;
    op_e                r_op;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [CNT_W-1:0]   r_cnt;
    logic [PW-1:0]      r_acc;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_b_zero;
    logic               w_last;
    logic [WIDTH:0]     w_add;
    logic [PW-1:0]      w_acc_next;
    logic [PW-1:0]      w_prod;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_diff;
    logic               w_fits;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;

    assign w_accept = (r_state == ST_IDLE) && (start_mult || start_div);
    assign w_b_zero = (b == {WIDTH{1'b0}});
    assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_W'(STEPS - 1));

    // Shift-add step: add the multiplicand into the upper half when the
    // multiplier LSB (bottom of the accumulator) is set, then shift right.
    assign w_add      = {1'b0, r_acc[PW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_add, r_acc[WIDTH-1:1]};
    assign w_prod     = r_neg_q ? (~w_acc_next + PW'(1)) : w_acc_next;

    // Restoring step: an extra top bit on the difference exposes the borrow.
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift} - {2'b00, r_opb};
    assign w_fits     = ~w_diff[WIDTH+1];
    assign w_rem_next = w_fits ? w_diff[WIDTH:0] : w_shift;
    assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
    assign w_quo_s    = r_neg_q ? f_neg(w_quo_next) : w_quo_next;
    assign w_rem_s    = r_neg_r ? f_neg(w_rem_next[WIDTH-1:0]) : w_rem_next[WIDTH-1:0];

    // FSM next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_mult) begin
                    w_next_state = ST_RUN;
                end else if (start_div) begin
                    w_next_state = w_b_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operation capture at acceptance, shared iteration counter, div_zero flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op       <= OP_MULT;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_opa      <= {WIDTH{1'b0}};
            r_opb      <= {WIDTH{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_op       <= start_mult ? OP_MULT : OP_DIV;
            r_neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r    <= a[WIDTH-1];
            r_opa      <= f_mag(a);
            r_opb      <= f_mag(b);
            r_cnt      <= {CNT_W{1'b0}};
            r_div_zero <= !start_mult && w_b_zero;
        end else if (r_state == ST_RUN) begin
            r_cnt      <= r_cnt + CNT_W'(1);
        end
    end

    // Multiply datapath: accumulator starts as {0, |b|}.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc <= {PW{1'b0}};
        end else if (w_accept) begin
            r_acc <= {{WIDTH{1'b0}}, f_mag(b)};
        end else if ((r_state == ST_RUN) && (r_op == OP_MULT)) begin
            r_acc <= w_acc_next;
        end
    end

    // Divide datapath: dividend magnitude shifts out of r_quo as quotient shifts in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rem <= {(WIDTH+1){1'b0}};
            r_quo <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_rem <= {(WIDTH+1){1'b0}};
            r_quo <= f_mag(a);
        end else if ((r_state == ST_RUN) && (r_op == OP_DIV)) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end

    // Result registers: loaded from the final iteration with sign fix-up.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
        end else if (w_last) begin
            if (r_op == OP_MULT) begin
                r_hi <= w_prod[PW-1:WIDTH];
                r_lo <= w_prod[WIDTH-1:0];
            end else begin
                r_hi <= w_rem_s;
                r_lo <= w_quo_s;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule
